// File: rtl/rv32i_pkg.sv
// Shared RV32 integer register-file constants for the default configuration.
package rv32i_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    typedef logic [REG_AW-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/rv32i_scoreboard.sv
// Pending-write scoreboard: one pending bit per register plus a live count.
// Flush clears everything, writeback clears one bit, issue sets one bit and
// wins over both so the newest owner of a register is never lost.
module rv32i_scoreboard #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [AW-1:0]     i_rd_addr,
    input  logic              i_issue,
    input  logic [AW-1:0]     i_issue_rd,
    input  logic              i_flush,
    output logic [DEPTH-1:0]  o_pending,
    output logic [AW:0]       o_pending_cnt
);

    logic [DEPTH-1:1] pend_q, pend_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             issue_v;
    logic             cnt_set;
    logic             cnt_clr;

    // x0 can never be pending, so its bit is a constant rather than a flop
    assign o_pending     = {pend_q, 1'b0};
    assign o_pending_cnt = cnt_q;
    assign issue_v       = i_issue && (i_issue_rd != '0);

    // Next pending bits: flush, then writeback clear, then issue set
    always_comb begin
        pend_d = pend_q;
        if (i_flush) begin
            pend_d = '0;
        end
        for (int unsigned r = 1; r < DEPTH; r++) begin
            if (i_we && (i_rd_addr == AW'(r))) begin
                pend_d[r] = 1'b0;
            end
            if (issue_v && (i_issue_rd == AW'(r))) begin
                pend_d[r] = 1'b1;
            end
        end
    end

    // Next count tracks the bit transitions exactly, so it cannot overrun
    always_comb begin
        cnt_set = issue_v && !o_pending[i_issue_rd];
        cnt_clr = i_we && o_pending[i_rd_addr] && !(issue_v && (i_issue_rd == i_rd_addr));
        if (i_flush) begin
            cnt_d = {{AW{1'b0}}, issue_v};
        end else begin
            cnt_d = cnt_q + (AW+1)'(cnt_set) - (AW+1)'(cnt_clr);
        end
    end

    // Scoreboard state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/rv32i_regfile_sb.sv
// N-read, 1-write integer register file with write-through bypass and a
// pending-write scoreboard for ID-stage hazard detection. x0 reads as zero.
module rv32i_regfile_sb
    import rv32i_pkg::*;
#(
    parameter int unsigned WIDTH = XLEN,
    parameter int unsigned DEPTH = 2 ** REG_AW,
    parameter int unsigned NREAD = 2,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREAD*AW-1:0]    i_rs_addr,
    output logic [NREAD*WIDTH-1:0] o_rs_data,
    output logic [NREAD-1:0]       o_rs_busy,
    input  logic                   i_we,
    input  logic [AW-1:0]          i_rd_addr,
    input  logic [WIDTH-1:0]       i_rd_data,
    input  logic                   i_issue,
    input  logic [AW-1:0]          i_issue_rd,
    input  logic                   i_flush,
    output logic [AW:0]            o_pending_cnt
);

    logic [WIDTH-1:0] regs_q   [DEPTH-1:1];
    logic [WIDTH-1:0] reg_view [DEPTH];
    logic [DEPTH-1:0] pending;
    logic             wr_en;
    logic             wb_live;

    assign wr_en   = i_we && (i_rd_addr != AW'(REG_ZERO));
    // Bypass is suppressed while in reset so every port reads zero
    assign wb_live = i_we && rst_n;

    // Flat view of storage with x0 tied to zero, so reads need no special range
    assign reg_view[0] = '0;
    for (genvar i = 1; i < DEPTH; i++) begin : g_view
        assign reg_view[i] = regs_q[i];
    end

    // Register storage; x0 is not stored and writes to it are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 1; r < DEPTH; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int unsigned r = 1; r < DEPTH; r++) begin
                if (wr_en && (i_rd_addr == AW'(r))) begin
                    regs_q[r] <= i_rd_data;
                end
            end
        end
    end

    rv32i_scoreboard #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_scoreboard (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_we          (i_we),
        .i_rd_addr     (i_rd_addr),
        .i_issue       (i_issue),
        .i_issue_rd    (i_issue_rd),
        .i_flush       (i_flush),
        .o_pending     (pending),
        .o_pending_cnt (o_pending_cnt)
    );

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0] addr;
        logic          hit;

        assign addr = i_rs_addr[k*AW +: AW];
        assign hit  = wb_live && (i_rd_addr == addr) && (addr != AW'(REG_ZERO));

        assign o_rs_data[k*WIDTH +: WIDTH] = hit ? i_rd_data : reg_view[addr];
        // A same-cycle writeback resolves the hazard because its data is bypassed
        assign o_rs_busy[k] = pending[addr] & ~hit;
    end

endmodule

// File: tb/tb_rv32i_regfile_sb.sv
// Directed bench for rv32i_regfile_sb (default 32x32, two read ports).
module tb_rv32i_regfile_sb;
    import rv32i_pkg::*;

    localparam int unsigned NREAD = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [2*5-1:0]    rs_addr;
    logic [2*32-1:0]   rs_data;
    logic [1:0]        rs_busy;
    logic              we;
    reg_addr_t         rd_addr;
    logic [31:0]       rd_data;
    logic              issue;
    reg_addr_t         issue_rd;
    logic              flush;
    logic [5:0]        pend_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rv32i_regfile_sb #(
        .WIDTH (32),
        .DEPTH (32),
        .NREAD (NREAD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_rs_addr     (rs_addr),
        .o_rs_data     (rs_data),
        .o_rs_busy     (rs_busy),
        .i_we          (we),
        .i_rd_addr     (rd_addr),
        .i_rd_data     (rd_data),
        .i_issue       (issue),
        .i_issue_rd    (issue_rd),
        .i_flush       (flush),
        .o_pending_cnt (pend_cnt)
    );

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic        issue;
        logic [4:0]  ird;
        logic        flush;
        logic [4:0]  rs0;
        logic [4:0]  rs1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  busy;
        logic [5:0]  cnt;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic w, input logic [4:0] rd, input logic [31:0] wd,
                                input logic is, input logic [4:0] ird, input logic fl,
                                input logic [4:0] r0, input logic [4:0] r1,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [1:0] b, input logic [5:0] c);
        vec_t v;
        v.we = w; v.rd = rd; v.wdata = wd; v.issue = is; v.ird = ird; v.flush = fl;
        v.rs0 = r0; v.rs1 = r1; v.d0 = d0; v.d1 = d1; v.busy = b; v.cnt = c;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [4:0] rd, input logic [31:0] wd,
                         input logic is, input logic [4:0] ird, input logic fl,
                         input logic [4:0] r0, input logic [4:0] r1);
        we = w; rd_addr = rd; rd_data = wd; issue = is; issue_rd = ird; flush = fl;
        rs_addr = {r1, r0};
    endtask

    initial begin
        // Sequence of cycles; data/busy are checked before the edge, cnt after it
        //            we rd  wdata         is ird fl  rs0 rs1  d0            d1            busy    cnt
        vecs[0]  = mk(1, 1,  32'hA5A5A5A5, 0, 0,  0,  1,  0,   32'hA5A5A5A5, 32'h0,        2'b00,  0);
        vecs[1]  = mk(0, 0,  32'h0,        0, 0,  0,  1,  1,   32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00,  0);
        vecs[2]  = mk(1, 0,  32'hFFFFFFFF, 1, 0,  0,  0,  0,   32'h0,        32'h0,        2'b00,  0);
        vecs[3]  = mk(0, 0,  32'h0,        0, 0,  0,  0,  0,   32'h0,        32'h0,        2'b00,  0);
        vecs[4]  = mk(1, 5,  32'h1234,     0, 0,  0,  5,  5,   32'h1234,     32'h1234,     2'b00,  0);
        vecs[5]  = mk(0, 0,  32'h0,        1, 3,  0,  3,  5,   32'h0,        32'h1234,     2'b00,  1);
        vecs[6]  = mk(0, 0,  32'h0,        0, 0,  0,  3,  3,   32'h0,        32'h0,        2'b11,  1);
        vecs[7]  = mk(1, 3,  32'h7,        0, 0,  0,  3,  1,   32'h7,        32'hA5A5A5A5, 2'b00,  0);
        vecs[8]  = mk(0, 0,  32'h0,        0, 0,  0,  3,  3,   32'h7,        32'h7,        2'b00,  0);
        vecs[9]  = mk(1, 3,  32'h9,        1, 3,  0,  3,  0,   32'h9,        32'h0,        2'b00,  1);
        vecs[10] = mk(0, 0,  32'h0,        0, 0,  0,  3,  1,   32'h9,        32'hA5A5A5A5, 2'b01,  1);
        vecs[11] = mk(0, 0,  32'h0,        1, 3,  0,  3,  3,   32'h9,        32'h9,        2'b11,  1);
        vecs[12] = mk(1, 3,  32'hB,        1, 2,  0,  3,  2,   32'hB,        32'h0,        2'b00,  1);
        vecs[13] = mk(0, 0,  32'h0,        1, 4,  0,  2,  3,   32'h0,        32'hB,        2'b01,  2);
        vecs[14] = mk(0, 0,  32'h0,        1, 6,  0,  4,  6,   32'h0,        32'h0,        2'b01,  3);
        vecs[15] = mk(0, 0,  32'h0,        1, 9,  1,  6,  9,   32'h0,        32'h0,        2'b01,  1);
        vecs[16] = mk(0, 0,  32'h0,        0, 0,  0,  9,  2,   32'h0,        32'h0,        2'b01,  1);
        vecs[17] = mk(0, 0,  32'h0,        0, 0,  0,  4,  6,   32'h0,        32'h0,        2'b00,  1);
        vecs[18] = mk(1, 6,  32'h66,       0, 0,  0,  6,  9,   32'h66,       32'h0,        2'b10,  1);
        vecs[19] = mk(1, 9,  32'h99,       0, 0,  0,  9,  6,   32'h99,       32'h66,       2'b00,  0);
        vecs[20] = mk(0, 0,  32'h0,        1, 0,  1,  9,  0,   32'h99,       32'h0,        2'b00,  0);

        drive(0, 0, 0, 0, 0, 0, 1, 2);
        repeat (2) @(posedge clk);
        #1;
        check("reset_d0", rs_data[31:0], 32'h0);
        check("reset_busy", {30'h0, rs_busy}, 32'h0);
        check("reset_cnt", {26'h0, pend_cnt}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].rd, vecs[i].wdata, vecs[i].issue, vecs[i].ird,
                  vecs[i].flush, vecs[i].rs0, vecs[i].rs1);
            #1;
            check($sformatf("v%0d_d0", i), rs_data[31:0], vecs[i].d0);
            check($sformatf("v%0d_d1", i), rs_data[63:32], vecs[i].d1);
            check($sformatf("v%0d_busy", i), {30'h0, rs_busy}, {30'h0, vecs[i].busy});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_cnt", i), {26'h0, pend_cnt}, {26'h0, vecs[i].cnt});
        end

        // Asynchronous reset between edges with x7 written and x8 pending
        @(negedge clk);
        drive(1, 7, 32'h77, 1, 8, 0, 7, 8);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 7, 8);
        #1;
        check("pre_rst_d0", rs_data[31:0], 32'h77);
        check("pre_rst_busy", {30'h0, rs_busy}, 32'h2);
        check("pre_rst_cnt", {26'h0, pend_cnt}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("in_rst_d0", rs_data[31:0], 32'h0);
        check("in_rst_busy", {30'h0, rs_busy}, 32'h0);
        check("in_rst_cnt", {26'h0, pend_cnt}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_x7", rs_data[31:0], 32'h0);
        check("post_rst_busy", {30'h0, rs_busy}, 32'h0);
        check("post_rst_cnt", {26'h0, pend_cnt}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
